// File: rtl/row_sync_engine.sv
// Miss-service engine behind the emulation row cache: writes back a dirty victim row,
// fetches the requested DRAM row into the cache-row RAM, then pulses sync for one cycle.
module row_sync_engine #(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 3,
    parameter int DWIDTH    = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          hold,
    input  logic [CHWIDTH-1:0]            cRowId,
    input  logic [ADDRWIDTH-1:0]          RowId,
    input  logic                          victim_valid,
    input  logic                          victim_dirty,
    input  logic [ADDRWIDTH-1:0]          victim_rowaddr,
    output logic                          sync,
    output logic                          busy,
    output logic [CHWIDTH+COLWIDTH-1:0]   cr_addr,
    output logic                          cr_we,
    output logic [DWIDTH-1:0]             cr_wdata,
    input  logic [DWIDTH-1:0]             cr_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDRWIDTH+COLWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]             mem_wdata,
    input  logic                          mem_ack,
    input  logic [DWIDTH-1:0]             mem_rdata
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WB_RD     = 3'd1;
    localparam logic [2:0] S_WB_REQ    = 3'd2;
    localparam logic [2:0] S_FETCH_REQ = 3'd3;
    localparam logic [2:0] S_FETCH_WR  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;
    localparam logic [2:0] S_WAIT_REL  = 3'd6;

    localparam logic [COLWIDTH-1:0] COL_LAST = '1;

    logic [2:0]           state_q, state_d;
    logic [COLWIDTH-1:0]  col_q, col_d;
    logic [CHWIDTH-1:0]   crow_q, crow_d;
    logic [ADDRWIDTH-1:0] rowid_q, rowid_d;
    logic [ADDRWIDTH-1:0] vaddr_q, vaddr_d;
    logic [DWIDTH-1:0]    wdata_q, wdata_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a variable unassigned (no latch).
        state_d = state_q;
        col_d   = col_q;
        crow_d  = crow_q;
        rowid_d = rowid_q;
        vaddr_d = vaddr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (hold) begin
                    crow_d  = cRowId;
                    rowid_d = RowId;
                    vaddr_d = victim_rowaddr;
                    col_d   = '0;
                    state_d = (victim_valid && victim_dirty) ? S_WB_RD : S_FETCH_REQ;
                end
            end
            // cr_addr is presented throughout WB_RD; its word is taken at the edge leaving it.
            S_WB_RD: begin
                wdata_d = cr_rdata;
                state_d = S_WB_REQ;
            end
            S_WB_REQ: begin
                if (mem_ack) begin
                    col_d   = col_q + COLWIDTH'(1);
                    state_d = (col_q == COL_LAST) ? S_FETCH_REQ : S_WB_RD;
                end
            end
            S_FETCH_REQ: begin
                if (mem_ack) begin
                    wdata_d = mem_rdata;
                    state_d = S_FETCH_WR;
                end
            end
            S_FETCH_WR: begin
                col_d   = col_q + COLWIDTH'(1);
                state_d = (col_q == COL_LAST) ? S_DONE : S_FETCH_REQ;
            end
            S_DONE: begin
                state_d = S_WAIT_REL;
            end
            // The cache drops hold one cycle after sync; waiting here stops a stale hold restarting us.
            S_WAIT_REL: begin
                if (!hold) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            crow_q  <= '0;
            rowid_q <= '0;
            vaddr_q <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            col_q   <= col_d;
            crow_q  <= crow_d;
            rowid_q <= rowid_d;
            vaddr_q <= vaddr_d;
            wdata_q <= wdata_d;
        end
    end

    // All outputs decode registered state only; nothing passes straight from an input.
    assign sync      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign cr_we     = (state_q == S_FETCH_WR);
    assign mem_req   = (state_q == S_WB_REQ) || (state_q == S_FETCH_REQ);
    assign mem_we    = (state_q == S_WB_REQ);
    assign cr_addr   = {crow_q, col_q};
    assign cr_wdata  = wdata_q;
    assign mem_wdata = wdata_q;
    assign mem_addr  = (state_q == S_WB_REQ) ? {vaddr_q, col_q} : {rowid_q, col_q};

endmodule

// File: tb/tb_row_sync_engine.sv
// Self-checking bench for row_sync_engine: directed and randomized misses checked against
// a transaction-level model of the expected memory traffic, cache writes and sync timing.
module tb_row_sync_engine;

    localparam int CHW = 5;
    localparam int AW  = 17;
    localparam int CW  = 3;
    localparam int DW  = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              hold = 1'b0;
    logic [CHW-1:0]    cRowId = '0;
    logic [AW-1:0]     RowId = '0;
    logic              victim_valid = 1'b0;
    logic              victim_dirty = 1'b0;
    logic [AW-1:0]     victim_rowaddr = '0;
    logic              sync, busy, cr_we, mem_req, mem_we;
    logic [CHW+CW-1:0] cr_addr;
    logic [DW-1:0]     cr_wdata, cr_rdata, mem_wdata;
    logic [AW+CW-1:0]  mem_addr;
    logic              mem_ack = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;

    row_sync_engine #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .cRowId(cRowId), .RowId(RowId),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_rowaddr(victim_rowaddr),
        .sync(sync), .busy(busy), .cr_addr(cr_addr), .cr_we(cr_we), .cr_wdata(cr_wdata),
        .cr_rdata(cr_rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          we;
        logic [AW+CW-1:0] addr;
        logic [DW-1:0] data;
    } mem_op_t;

    mem_op_t           mem_log[$];
    logic [CHW+CW-1:0] cr_addr_log[$];
    logic [DW-1:0]     cr_data_log[$];
    int                sync_log[$];
    int                cyc = 0;
    int                unstable = 0;
    int                drop_viol = 0;
    int                ack_delay = 0;
    bit                spurious_ack = 1'b0;
    logic [DW-1:0]     fetch_data[8];
    logic [DW-1:0]     ram[256];
    int                n_checks = 0;
    int                n_pass = 0;
    int                n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cache-row RAM: the word for the address driven in a cycle is taken by the DUT at the next edge.
    assign cr_rdata = ram[cr_addr];

    // Backing memory: acks after ack_delay waiting cycles, logs each accepted request.
    bit      pending = 1'b0;
    int      wait_cnt = 0;
    mem_op_t req_snap;
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack = 1'b0;
            pending = 1'b0;
            wait_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!pending) begin
                    pending  = 1'b1;
                    wait_cnt = 0;
                    req_snap = '{we: mem_we, addr: mem_addr, data: mem_wdata};
                end else if (mem_we !== req_snap.we || mem_addr !== req_snap.addr ||
                             (req_snap.we && mem_wdata !== req_snap.data)) begin
                    unstable++;
                end
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = fetch_data[mem_addr[CW-1:0]];
                    mem_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
                    pending   = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                if (pending) drop_viol++;
                pending = 1'b0;
                if (spurious_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (cr_we) begin
                cr_addr_log.push_back(cr_addr);
                cr_data_log.push_back(cr_wdata);
            end
            if (sync) sync_log.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One miss: expected traffic is optional 8-word writeback of the victim row, then 8 reads of
    // the requested row; sync lands 2 cycles per word plus one cycle per memory wait.
    task automatic do_miss(input logic [CHW-1:0] crow, input logic [AW-1:0] rowid,
                           input logic vv, input logic vd, input logic [AW-1:0] vaddr,
                           input int delay, input int hold_after, input bit drop_early,
                           input bit scramble, input logic [DW-1:0] fbase);
        logic [DW-1:0] src[8];
        bit wb, seen;
        int nwb, total, lat, t0, mb, cb, sb, u0, d0;
        wb    = vv & vd;
        nwb   = wb ? 8 : 0;
        total = nwb + 8;
        lat   = 2 * total + total * delay;
        @(negedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            src[k]        = ram[{crow, 3'(k)}];
            fetch_data[k] = (fbase != 0) ? fbase + 64'(k) : {$urandom, $urandom};
        end
        ack_delay = delay;
        mb = mem_log.size(); cb = cr_data_log.size(); sb = sync_log.size();
        u0 = unstable; d0 = drop_viol;
        cRowId = crow; RowId = rowid; victim_valid = vv; victim_dirty = vd; victim_rowaddr = vaddr;
        hold = 1'b1;
        t0 = cyc + 1;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk); #1;
            if (i == 1) check("busy_active", busy, 1);
            if (drop_early && i == 3) hold = 1'b0;
            if (scramble) begin
                cRowId = 5'($urandom); RowId = 17'($urandom); victim_rowaddr = 17'($urandom);
                victim_valid = 1'($urandom); victim_dirty = 1'($urandom);
            end
            seen = (sync_log.size() > sb);
        end
        check("sync_seen", sync_log.size() - sb, 1);
        check("sync_cycle", (sync_log.size() > sb) ? sync_log[sb] : -1, t0 + lat);
        for (int i = 0; i < hold_after; i++) begin
            @(negedge clk); #1;
        end
        if (hold_after > 0) check("wait_rel_busy", busy, 1);
        hold = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
        end
        check("idle_after_release", busy, 0);
        check("sync_count", sync_log.size() - sb, 1);
        check("mem_op_count", mem_log.size() - mb, total);
        for (int i = 0; i < total; i++) begin
            if (mb + i < mem_log.size()) begin
                mem_op_t op;
                logic [AW+CW-1:0] ea;
                op = mem_log[mb + i];
                ea = (i < nwb) ? {vaddr, 3'(i)} : {rowid, 3'(i - nwb)};
                check($sformatf("mem_we[%0d]", i), op.we, (i < nwb));
                check($sformatf("mem_addr[%0d]", i), op.addr, ea);
                if (i < nwb) check($sformatf("mem_wdata[%0d]", i), op.data, src[i]);
            end
        end
        check("cr_write_count", cr_data_log.size() - cb, 8);
        for (int k = 0; k < 8; k++) begin
            if (cb + k < cr_data_log.size()) begin
                check($sformatf("cr_addr[%0d]", k), cr_addr_log[cb + k], {crow, 3'(k)});
                check($sformatf("cr_wdata[%0d]", k), cr_data_log[cb + k], fetch_data[k]);
            end
        end
        check("mem_req_stable", unstable - u0, 0);
        check("mem_req_held_to_ack", drop_viol - d0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", {sync, busy, cr_we, mem_req, mem_we}, 0);
        check("reset_cr_addr", cr_addr, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        check("reset_cr_wdata", cr_wdata, 0);
        rst_n = 1'b1;

        // Clean miss, invalid victim.
        do_miss(5'd3, 17'h000A5, 1'b0, 1'b0, 17'h0, 0, 0, 1'b0, 1'b0, 64'h100);

        // Dirty eviction of row 5 to the top DRAM row.
        for (int k = 0; k < 8; k++) ram[{5'd5, 3'(k)}] = 64'hA0 + 64'(k);
        do_miss(5'd5, 17'($urandom), 1'b1, 1'b1, 17'h1FFFF, 0, 0, 1'b0, 1'b0, 64'h0);

        // Three wait cycles on every request.
        do_miss(5'd3, 17'h000A5, 1'b0, 1'b0, 17'h0, 3, 0, 1'b0, 1'b0, 64'h100);

        // Valid but clean victim: no writeback.
        do_miss(5'd3, 17'h000A5, 1'b1, 1'b0, 17'($urandom), 0, 0, 1'b0, 1'b0, 64'h100);

        // hold kept high 5 cycles after sync.
        do_miss(5'd9, 17'($urandom), 1'b0, 1'b1, 17'($urandom), 0, 5, 1'b0, 1'b0, 64'h0);

        // Early hold drop, scrambled inputs, stray acks, one wait cycle, dirty victim.
        spurious_ack = 1'b1;
        do_miss(5'd30, 17'($urandom), 1'b1, 1'b1, 17'($urandom), 1, 0, 1'b1, 1'b1, 64'h0);
        spurious_ack = 1'b0;

        for (int r = 0; r < 3; r++) begin
            do_miss(5'($urandom), 17'($urandom), 1'($urandom), 1'($urandom), 17'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0, 1'b0, 64'h0);
        end

        // Reset while fetching word 4, then a fresh miss.
        for (int k = 0; k < 8; k++) fetch_data[k] = {$urandom, $urandom};
        ack_delay = 0;
        @(negedge clk); #1;
        cRowId = 5'd7; RowId = 17'h0BEEF; victim_valid = 1'b0; victim_dirty = 1'b0;
        hold = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk); #1;
            found = mem_req && !mem_we && (mem_addr[CW-1:0] == 3'd4);
        end
        check("reached_word4", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_cr_we", cr_we, 0);
        check("rst_busy", busy, 0);
        hold = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        do_miss(5'd7, 17'h0BEEF, 1'b0, 1'b0, 17'h0, 0, 0, 1'b0, 1'b0, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/row_sync_engine.md
Name: row_sync_engine

Overview:
Miss-service stage directly downstream of the emulation row cache. When the cache raises hold on a read or write miss, this block does two things in order. First, it writes the victim cache row back to backing memory if that row is valid and dirty. Second, it fetches the requested DRAM row from backing memory into the cache-row RAM. It then pulses sync for one cycle so the cache can leave RDMiss/WRMiss. It talks to the cache-row RAM (1-cycle read latency) and to a req/ack backing-memory port.

Parameters:
CHWIDTH, 5, log2 of cache rows; width of the cache row id
ADDRWIDTH, 17, DRAM row address width
COLWIDTH, 3, log2 of words per row (8 words)
DWIDTH, 64, data word width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
hold  in  1  miss request from cache (level)
cRowId  in  CHWIDTH  victim/target cache row id
RowId  in  ADDRWIDTH  requested DRAM row
victim_valid  in  1  victim row holds data
victim_dirty  in  1  victim row modified
victim_rowaddr  in  ADDRWIDTH  DRAM row currently held by victim
sync  out  1  one-cycle completion pulse to cache
busy  out  1  high in every state except IDLE
cr_addr  out  CHWIDTH+COLWIDTH  cache-row RAM word address {row, col}
cr_we  out  1  cache-row RAM write enable
cr_wdata  out  DWIDTH  cache-row RAM write data
cr_rdata  in  DWIDTH  cache-row RAM read data, valid the cycle after cr_addr
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDRWIDTH+COLWIDTH  backing word address {row, col}
mem_wdata  out  DWIDTH  write data
mem_ack  in  1  request accepted/completed this cycle
mem_rdata  in  DWIDTH  read data, valid with mem_ack on reads

Behaviour:
- Reset (rst_n low, async): state IDLE; col counter 0. Outputs sync=0, busy=0, cr_we=0, mem_req=0, mem_we=0. All address and data outputs are 0.
- All outputs are registered or decoded purely from registered state. There is no combinational path from input to output.
- States: IDLE, WB_RD, WB_REQ, FETCH_REQ, FETCH_WR, DONE, WAIT_REL.
- IDLE:
  - On a clock edge with hold=1, latch cRowId, RowId, victim_rowaddr and wb = victim_valid & victim_dirty. Set col=0.
  - If wb, go to WB_RD; otherwise go to FETCH_REQ.
- WB_RD: drive cr_addr={row,col}. Go to WB_REQ and capture cr_rdata on entry into a wdata register.
- WB_REQ:
  - Drive mem_req=1, mem_we=1, mem_addr={victim_rowaddr,col}, mem_wdata=captured word.
  - Signals stay stable until an edge with mem_ack=1.
  - On ack, col++. If col was 2^COLWIDTH-1, set col=0 and go to FETCH_REQ; otherwise go to WB_RD.
- FETCH_REQ:
  - Drive mem_req=1, mem_we=0, mem_addr={RowId_latched,col}. Hold until mem_ack.
  - On ack, capture mem_rdata and go to FETCH_WR.
- FETCH_WR:
  - Drive cr_we=1 for exactly one cycle, with cr_addr={row,col} and cr_wdata=captured word. Then col++.
  - If col was last, go to DONE; otherwise go to FETCH_REQ.
- DONE: sync=1 for exactly one cycle, then go to WAIT_REL.
- WAIT_REL: stay until an edge with hold=0, then go to IDLE. This prevents retriggering on the cache's registered hold, which falls one cycle after sync.
- Latency with zero-wait memory (ack in first req cycle), counting edge t0 as the edge that samples hold:
  - Clean or invalid victim: sync is high in the cycle after edge t0+16.
  - Dirty victim: sync is high in the cycle after edge t0+32.
  - Each extra wait cycle on mem_ack adds 1 cycle.
- Boundary conditions:
  - mem_ack outside WB_REQ/FETCH_REQ is ignored.
  - hold dropping mid-transfer is ignored; the transfer completes and sync still pulses.
  - Input changes after the start latch are ignored.
  - The col counter is COLWIDTH bits and wraps to 0 after the last word.
  - Reset mid-transfer drops mem_req immediately. The partially filled row is abandoned; the cache is reset alongside.
  - mem_req never deasserts before ack, except on reset.

Test Plan:
- Clean miss: victim_valid=0, RowId=0x00A5, cRowId=3, memory returns word k = 0x100+k with 0-wait ack -> 8 mem reads at addresses {0x00A5,0..7}; cr writes at {3,0..7} with 0x100..0x107; sync is one 1-cycle pulse 16 cycles after the start edge.
- Dirty eviction: valid=1, dirty=1, victim_rowaddr=0x1FFFF, cache row 5 preloaded with 0xA0..0xA7 -> 8 mem writes at {0x1FFFF,0..7} with 0xA0..0xA7 before any read; then 8 fetches; sync at +32.
- Wait states: ack delayed 3 cycles on every request, clean miss -> mem_addr/mem_req are stable while waiting; sync at +16+8*3=+40.
- Valid but clean victim (dirty=0) -> no mem_we=1 cycles; behaviour identical to scenario 1.
- Retrigger guard: hold held high 5 cycles after sync -> no second transfer; busy stays 1 in WAIT_REL, then 0 when hold falls. A new hold afterwards starts a new transfer.
- Reset mid-fetch at word 4 -> mem_req, cr_we and busy are 0 immediately (async). After release, a new hold restarts at col=0.
